axi_bank_delay: RTL and testbench

- Parametrised successor to the single-page AXI address-channel delay gate; sits between the AXI FIFO master port and the RAM model on an AR or AW channel inside the DRAM wrapper.
- Tracks one open row per bank and classifies each request as hit, miss (bank closed) or conflict (other row open).
- Holds the valid/ready handshake for a class-specific number of cycles.
- Adds close-page mode and a periodic refresh that closes all banks.

---
 rtl/axi_bank_delay.sv | 182 ++++++++++++++++++
 tb/tb_axi_bank_delay.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_bank_delay.sv
// Per-bank open-row tracker that stalls an AXI address handshake by a hit/miss/conflict delay.
// Latency D+1 edges from acceptance to out_valid; PASS waits indefinitely for in_ready, one request in flight.
module axi_bank_delay #(
   parameter int ADDR_WIDTH        = 16,
   parameter int PAGE_OFFSET_WIDTH = 6,
   parameter int BANK_WIDTH        = 2,
   parameter int CNT_WIDTH         = 5,
   parameter int HIT_DELAY         = 2,
   parameter int MISS_DELAY        = 8,
   parameter int CONFLICT_DELAY    = 16,
   parameter int CLOSE_PAGE        = 0,
   parameter int REFRESH_INTERVAL  = 0,
   parameter int REFRESH_DELAY     = 8,
   parameter int REFRESH_CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [ADDR_WIDTH-1:0]        in_addr,
   input  logic                         in_ready,
   output logic                         out_valid,
   output logic                         out_ready,
   output logic                         hit,
   output logic                         miss,
   output logic                         conflict,
   output logic [(2**BANK_WIDTH)-1:0]   open_banks,
   output logic                         busy
);

   localparam int NUM_BANKS = 2**BANK_WIDTH;
   localparam int ROW_WIDTH = ADDR_WIDTH - PAGE_OFFSET_WIDTH - BANK_WIDTH;
   localparam logic [CNT_WIDTH-1:0]         CNT_ONE = CNT_WIDTH'(1);
   localparam logic [REFRESH_CNT_WIDTH-1:0] REF_ONE = REFRESH_CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      PASS    = 2'd2,
      REFRESH = 2'd3
   } state_t;

   state_t                       state, state_nxt;
   logic [CNT_WIDTH-1:0]         cnt, cnt_nxt;
   logic [CNT_WIDTH-1:0]         class_delay;
   logic [NUM_BANKS-1:0]         open_q;
   logic [ROW_WIDTH-1:0]         row_q [NUM_BANKS];
   logic [BANK_WIDTH-1:0]        req_bank, cur_bank;
   logic [ROW_WIDTH-1:0]         req_row, cur_row;
   logic [REFRESH_CNT_WIDTH-1:0] ref_cnt;
   logic                         ref_pending, ref_wrap;
   logic                         accept, handshake, refresh_done;
   logic                         row_open, row_match;

   assign req_bank     = in_addr[PAGE_OFFSET_WIDTH +: BANK_WIDTH];
   assign req_row      = in_addr[ADDR_WIDTH-1 -: ROW_WIDTH];
   assign row_open     = open_q[req_bank];
   assign row_match    = (row_q[req_bank] == req_row);
   assign accept       = (state == IDLE) && in_valid && !ref_pending;
   assign handshake    = (state == PASS) && in_valid && in_ready;
   assign refresh_done = (state == REFRESH) && (cnt <= CNT_ONE);

   always_comb begin
      class_delay = CNT_WIDTH'(CONFLICT_DELAY);
      if (!row_open)
         class_delay = CNT_WIDTH'(MISS_DELAY);
      else if (row_match)
         class_delay = CNT_WIDTH'(HIT_DELAY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            // Refresh takes priority over a request arriving in the same cycle.
            if (ref_pending) begin
               state_nxt = REFRESH;
               cnt_nxt   = CNT_WIDTH'(REFRESH_DELAY);
            end else if (in_valid) begin
               cnt_nxt   = class_delay;
               state_nxt = (class_delay == '0) ? PASS : WAIT;
            end
         end
         WAIT: begin
            if (!in_valid) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = (cnt != '0) ? cnt - CNT_ONE : '0;
               if (cnt <= CNT_ONE)
                  state_nxt = PASS;
            end
         end
         PASS: begin
            if (handshake)
               state_nxt = IDLE;
         end
         REFRESH: begin
            cnt_nxt = (cnt != '0) ? cnt - CNT_ONE : '0;
            if (cnt <= CNT_ONE)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_ready = 1'b0;
      hit       = 1'b0;
      miss      = 1'b0;
      conflict  = 1'b0;
      case (state)
         PASS: begin
            out_valid = in_valid;
            out_ready = in_ready;
         end
         IDLE: begin
            // Pulses are suppressed while reset is held so every output reads 0.
            if (in_valid && !ref_pending && rst) begin
               hit      = row_open && row_match;
               miss     = !row_open;
               conflict = row_open && !row_match;
            end
         end
         default: ;
      endcase
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         open_q <= '0;
      else if (refresh_done)
         open_q <= '0;
      else if (handshake)
         open_q[cur_bank] <= (CLOSE_PAGE == 0);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cur_bank <= req_bank;
         cur_row  <= req_row;
      end
      if (handshake)
         row_q[cur_bank] <= cur_row;
   end

   assign open_banks = open_q;

   assign ref_wrap = (REFRESH_INTERVAL != 0) &&
                     (ref_cnt == REFRESH_CNT_WIDTH'(REFRESH_INTERVAL - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_cnt     <= '0;
         ref_pending <= 1'b0;
      end else begin
         if (REFRESH_INTERVAL != 0)
            ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_ONE;
         // A wrap landing on the refresh exit edge re-arms the next refresh.
         if (ref_wrap)
            ref_pending <= 1'b1;
         else if (refresh_done)
            ref_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_bank_delay.sv
// Directed bench for axi_bank_delay: default, refresh-enabled and close-page instances on one clock.
module tb_axi_bank_delay;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, ready;
   logic [15:0] addr;
   int          sel;
   int          checks = 0;
   int          errors = 0;
   int          cyc;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   logic       d_ov, d_or, d_h, d_m, d_c, d_b;
   logic [3:0] d_ob;
   logic       r_ov, r_or, r_h, r_m, r_c, r_b;
   logic [3:0] r_ob;
   logic       p_ov, p_or, p_h, p_m, p_c, p_b;
   logic [3:0] p_ob;
   logic       d_iv, r_iv, p_iv;

   assign d_iv = valid && (sel == 0);
   assign r_iv = valid && (sel == 1);
   assign p_iv = valid && (sel == 2);

   axi_bank_delay u_dut (
      .clk(clk), .rst(rst), .in_valid(d_iv), .in_addr(addr), .in_ready(ready),
      .out_valid(d_ov), .out_ready(d_or), .hit(d_h), .miss(d_m), .conflict(d_c),
      .open_banks(d_ob), .busy(d_b));

   axi_bank_delay #(.REFRESH_INTERVAL(64), .REFRESH_DELAY(8)) u_ref (
      .clk(clk), .rst(rst), .in_valid(r_iv), .in_addr(addr), .in_ready(ready),
      .out_valid(r_ov), .out_ready(r_or), .hit(r_h), .miss(r_m), .conflict(r_c),
      .open_banks(r_ob), .busy(r_b));

   axi_bank_delay #(.CLOSE_PAGE(1)) u_cp (
      .clk(clk), .rst(rst), .in_valid(p_iv), .in_addr(addr), .in_ready(ready),
      .out_valid(p_ov), .out_ready(p_or), .hit(p_h), .miss(p_m), .conflict(p_c),
      .open_banks(p_ob), .busy(p_b));

   logic       ov, ordy, busy;
   logic [2:0] cls;
   logic [3:0] ob;

   always_comb begin
      ov = d_ov; ordy = d_or; busy = d_b; cls = {d_h, d_m, d_c}; ob = d_ob;
      if (sel == 1) begin
         ov = r_ov; ordy = r_or; busy = r_b; cls = {r_h, r_m, r_c}; ob = r_ob;
      end else if (sel == 2) begin
         ov = p_ov; ordy = p_or; busy = p_b; cls = {p_h, p_m, p_c}; ob = p_ob;
      end
   end

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  cls;     // {hit, miss, conflict}
      int          lat;     // negedges from request until out_valid is seen
      int          stall;   // cycles in_ready is held low once in PASS
      logic [3:0]  ob;      // open_banks after the handshake
   } vec_t;

   localparam logic [2:0] C_HIT = 3'b100, C_MISS = 3'b010, C_CONF = 3'b001;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      bit seen;
      bit gate_ok;
      @(negedge clk);
      valid = 1'b1;
      addr  = v.addr;
      ready = (v.stall == 0);
      #1;
      check("class", cls, v.cls);
      seen    = 1'b0;
      gate_ok = 1'b1;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk); #1;
         if (ov) begin
            seen = 1'b1;
            break;
         end
         if (ordy || (cls != 3'b000)) gate_ok = 1'b0;
      end
      check("wait_gating", gate_ok, 1);
      check("latency", seen ? n : 0, v.lat);
      for (int s = 0; s < v.stall; s++) begin
         check("stall", {ov, ordy}, 2'b10);
         @(negedge clk); #1;
      end
      ready = 1'b1;
      #1;
      check("pass", {ov, ordy}, 2'b11);
      @(negedge clk);
      valid = 1'b0;
      ready = 1'b0;
      #1;
      check("done_idle", {busy, ov}, 2'b00);
      check("open_banks", ob, v.ob);
   endtask

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'h0040, C_MISS, 9,  0, 4'b0010};
      tbl[1] = '{16'h0044, C_HIT,  3,  0, 4'b0010};
      tbl[2] = '{16'h0140, C_CONF, 17, 0, 4'b0010};
      tbl[3] = '{16'h0140, C_HIT,  3,  5, 4'b0010};
      tbl[4] = '{16'h00C0, C_MISS, 9,  0, 4'b1010};
      tbl[5] = '{16'h0000, C_MISS, 9,  0, 4'b1011};
      tbl[6] = '{16'h0080, C_MISS, 9,  0, 4'b1111};
      tbl[7] = '{16'hFFC0, C_CONF, 17, 0, 4'b1111};
      tbl[8] = '{16'hFFFF, C_HIT,  3,  0, 4'b1111};
      tbl[9] = '{16'h0004, C_HIT,  3,  2, 4'b1111};

      // Reset with a request already presented: every output must stay low.
      sel = 0; rst = 1'b0; valid = 1'b1; ready = 1'b1; addr = 16'h0040;
      #3;
      check("reset_outputs", {ov, ordy, busy, cls, ob}, 11'h0);
      repeat (2) @(negedge clk);
      valid = 1'b0; ready = 1'b0;
      rst = 1'b1;

      // Refresh instance: open bank1, then present a request after the first wrap.
      sel = 1;
      run_vec('{16'h0040, C_MISS, 9, 0, 4'b0010});
      while (cyc < 64) @(negedge clk);
      valid = 1'b1; addr = 16'h0040; ready = 1'b1;
      #1;
      check("refresh_wins", {busy, ov, cls}, 5'b00000);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check("refresh_busy", {busy, ov, ordy, ob}, {3'b100, 4'b0010});
      end
      @(negedge clk); #1;
      check("refresh_exit", {busy, ob}, 5'b00000);
      check("refresh_then_miss", cls, C_MISS);
      valid = 1'b0; ready = 1'b0;

      // Default instance: directed vectors.
      sel = 0;
      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // Reset in the middle of WAIT on a conflict to bank1.
      @(negedge clk);
      valid = 1'b1; addr = 16'h0040; ready = 1'b1;
      #1;
      check("mid_wait_class", cls, C_CONF);
      repeat (4) @(negedge clk);
      #1;
      check("mid_wait_busy", {busy, ov, ordy}, 3'b100);
      rst = 1'b0;
      #1;
      check("async_reset", {ov, ordy, busy, cls, ob}, 11'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_reset_miss", {cls, ob}, {C_MISS, 4'b0000});
      valid = 1'b0; ready = 1'b0;
      run_vec('{16'h0040, C_MISS, 9, 0, 4'b0010});

      // Close-page instance: repeated access never finds the row open.
      sel = 2;
      run_vec('{16'h0040, C_MISS, 9, 0, 4'b0000});
      run_vec('{16'h0040, C_MISS, 9, 0, 4'b0000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
